rs_station_aged: RTL and testbench
==================================

# rs_station_aged

Parametrised out-of-order reservation station between the decoder/issue stage and the ALU. It generalises the single-ALU station with configurable depth, operand width, tag width and number of CDB broadcast channels. It adds oldest-first dispatch through an age matrix, a valid/ready dispatch handshake with back-pressure, and same-cycle CDB capture at insert.

## Interface
- `DEPTH`, 16: number of entries, ≥2.
- `XLEN`, 32: operand, immediate and PC width.
- `TAGW`, 5: ROB tag width.
- `NCDB`, 2: number of CDB broadcast channels (ALU, load, ...).
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `rdy` in 1: global enable. When low, all state holds.
- `jump_wrong_stall` in 1: misprediction flush.
- `issue_valid` in 1: issue an instruction this cycle.
- `issue_vq1`, `issue_vq2` in XLEN: operand value, or tag in low TAGW bits when not ready.
- `issue_rdy1`, `issue_rdy2` in 1: operand holds a value.
- `issue_a`, `issue_pc` in XLEN: immediate and PC.
- `issue_code` in 6: opcode.
- `issue_rob_id` in TAGW: destination tag.
- `rs_nex_ava` out 1: an issue next cycle is guaranteed to be accepted.
- `rs_count` out clog2(DEPTH+1): occupied entries.
- `alu_valid` out 1, `alu_ready` in 1: dispatch handshake.
- `alu_v1`, `alu_v2`, `alu_a`, `alu_pc` out XLEN; `alu_code` out 6; `alu_rob_id` out TAGW.
- `cdb_valid` in NCDB, `cdb_tag` in NCDB×TAGW, `cdb_val` in NCDB×XLEN: packed broadcast channels.

## Operation
- Entry state: busy, rdy1/2, vq1/2, a, pc, code, rob_id, plus an age row `older[i][j]` (entry j is older than i).
- Insert:
  - The lowest-index free entry is used.
  - The age row is set to the current busy vector.
  - Column i is cleared in all other rows.
- Wakeup: every busy entry with a not-ready operand compares its tag against each valid CDB channel and captures the value on a match.
  - If multiple channels match, the lowest channel index wins. Duplicate tags are illegal, so this is an assertion case.
- Insert capture: an incoming not-ready operand whose tag matches a same-cycle CDB broadcast is stored as ready with the broadcast value.
- Select: among busy entries with both operands ready, choose the one whose `older` row ANDed with the ready vector is zero (the oldest).
- Dispatch fires when a selection exists and (`!alu_valid || alu_ready`).
  - The output registers load the entry and the entry's busy bit clears.
  - If there is no selection and `alu_ready` is high, `alu_valid` drops.
  - While `alu_valid && !alu_ready`, all outputs hold unchanged.
- Availability: `rs_nex_ava = free≥2 || (free==1 && !issue_valid) || dispatch_fire`.
- Issue while full without a same-cycle dispatch is dropped. This is an assertion error.
- Flush and reset:
  - Both clear all busy bits, `alu_valid` and the age matrix.
  - Both take priority over `rdy`, insert and dispatch.

## Timing
- Reset values:
  - `alu_valid`=0 and all alu_* data outputs are 0.
  - `rs_count`=0.
  - `rs_nex_ava`=1.
- Issue at edge t with both operands ready: the entry is selectable in cycle t+1, and `alu_valid` is high after edge t+1. Minimum latency is 2 cycles from `issue_valid`.
- A CDB broadcast at edge t makes the entry ready in cycle t+1. There is no bypass into select in the same cycle.
- A same-cycle insert and dispatch of a different entry are both honoured. A freed slot is reusable on the next edge.
- With `rdy` low, no state changes and outputs hold. The handshake is not consumed.
- `rs_count` and `rs_nex_ava` are computed from registered busy state. `rs_nex_ava` additionally depends combinationally on `issue_valid` and `alu_ready`.

## Structure
- Shared package (Def): `True`/`False`, opcode width 6, the default `DEPTH`/`TAGW`, and the type enum for RS-bound instructions.
- Sub-module `rs_age_matrix` (DEPTH):
  - Inputs: alloc one-hot, free one-hot, request vector.
  - Output: one-hot oldest grant.
- Free-slot pick, tag compare and output registers stay in the top level.

## Test plan
- Reset, then issue ADD with v1=5, v2=7 ready at cycle 1:
  - `alu_valid`=1 in cycle 3 with v1=5, v2=7.
  - `rs_count` goes 0→1→0.
- Issue A (waiting on tag 3), then B (ready). Broadcast tag 3, val=0x10 on channel 1 at cycle 4:
  - B dispatches first.
  - A dispatches after, with v1=0x10.
- Fill all DEPTH entries ready, hold `alu_ready`=0 for 5 cycles:
  - Outputs stay stable and `rs_nex_ava`=0.
  - On release, entries dispatch strictly in issue order.
- Issue with `issue_rdy2`=0, tag 9, while the CDB broadcasts tag 9, val=0xAB:
  - Entry is stored ready.
  - It dispatches with v2=0xAB two cycles later.
- Fill 3 entries, raise `jump_wrong_stall` with `alu_valid`=1 and `rdy`=0:
  - Next cycle `rs_count`=0, `alu_valid`=0 and `rs_nex_ava`=1.
- At DEPTH-1 occupancy, issue and dispatch in the same cycle:
  - `rs_nex_ava` stays 1.
  - Count is unchanged and no issue is dropped.

Source files
------------

// File: rtl/rs_station_aged_pkg.sv
// Shared definitions for the aged reservation station: boolean constants,
// opcode width, default geometry and the opcodes of RS-bound instructions.
package rs_station_aged_pkg;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam int unsigned OPW       = 6;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_TAGW  = 5;

  // Instruction types the decoder routes to this station.
  typedef enum logic [OPW-1:0] {
    OP_ADD  = 6'd0,
    OP_SUB  = 6'd1,
    OP_AND  = 6'd2,
    OP_OR   = 6'd3,
    OP_XOR  = 6'd4,
    OP_SLL  = 6'd5,
    OP_SRL  = 6'd6,
    OP_SRA  = 6'd7,
    OP_SLT  = 6'd8,
    OP_SLTU = 6'd9,
    OP_BEQ  = 6'd16,
    OP_BNE  = 6'd17,
    OP_JAL  = 6'd24,
    OP_JALR = 6'd25
  } rs_op_e;

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: tracks relative allocation order of the station entries and
// grants the oldest requesting entry (one-hot).
module rs_age_matrix
  import rs_station_aged_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] free,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant
);

  // older[i][j] set means entry j was allocated before entry i.
  logic [DEPTH-1:0] older [DEPTH];
  logic [DEPTH-1:0] occ;

  // Oldest requester: no other requester is older than it.
  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      grant[i] = req[i] && ((older[i] & req) == '0);
    end
  end

  // New entry becomes younger than every live entry; stale column bits from a
  // previous occupant of the slot are wiped when the slot is reallocated.
  always_ff @(posedge clk) begin
    if (clr) begin
      occ <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        older[i] <= '0;
      end
    end else begin
      occ <= (occ & ~free) | alloc;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (alloc[i]) begin
          older[i] <= occ & ~free & ~alloc;
        end else begin
          older[i] <= older[i] & ~alloc;
        end
      end
    end
  end

endmodule

// File: rtl/rs_station_aged.sv
// Out-of-order reservation station with oldest-first dispatch, multi-channel
// CDB wakeup, same-cycle CDB capture at insert and a valid/ready ALU port.
module rs_station_aged
  import rs_station_aged_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAGW  = DEF_TAGW,
  parameter int unsigned NCDB  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       jump_wrong_stall,
  input  logic                       issue_valid,
  input  logic [XLEN-1:0]            issue_vq1,
  input  logic [XLEN-1:0]            issue_vq2,
  input  logic                       issue_rdy1,
  input  logic                       issue_rdy2,
  input  logic [XLEN-1:0]            issue_a,
  input  logic [XLEN-1:0]            issue_pc,
  input  logic [OPW-1:0]             issue_code,
  input  logic [TAGW-1:0]            issue_rob_id,
  output logic                       rs_nex_ava,
  output logic [$clog2(DEPTH+1)-1:0] rs_count,
  output logic                       alu_valid,
  input  logic                       alu_ready,
  output logic [XLEN-1:0]            alu_v1,
  output logic [XLEN-1:0]            alu_v2,
  output logic [XLEN-1:0]            alu_a,
  output logic [XLEN-1:0]            alu_pc,
  output logic [OPW-1:0]             alu_code,
  output logic [TAGW-1:0]            alu_rob_id,
  input  logic [NCDB-1:0]            cdb_valid,
  input  logic [NCDB*TAGW-1:0]       cdb_tag,
  input  logic [NCDB*XLEN-1:0]       cdb_val
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] busy, rdy1_q, rdy2_q;
  logic [XLEN-1:0]  vq1_q [DEPTH];
  logic [XLEN-1:0]  vq2_q [DEPTH];
  logic [XLEN-1:0]  a_q   [DEPTH];
  logic [XLEN-1:0]  pc_q  [DEPTH];
  logic [OPW-1:0]   code_q[DEPTH];
  logic [TAGW-1:0]  rob_q [DEPTH];

  logic [DEPTH-1:0] ready_vec, sel_oh, ins_oh, alloc_oh, free_oh;
  logic             slot_found, fire, insert, flush;
  logic [CW-1:0]    cnt, free_cnt;
  logic [XLEN:0]    wk1 [DEPTH];
  logic [XLEN:0]    wk2 [DEPTH];
  logic [XLEN:0]    in1, in2;
  logic [XLEN-1:0]  sel_v1, sel_v2, sel_a, sel_pc;
  logic [OPW-1:0]   sel_code;
  logic [TAGW-1:0]  sel_rob;

  // {hit, value} of the lowest-index valid CDB channel carrying this tag.
  function automatic logic [XLEN:0] cdb_lookup(input logic [TAGW-1:0] tag);
    logic [XLEN:0] r;
    r = '0;
    for (int unsigned c = 0; c < NCDB; c++) begin
      if (!r[XLEN] && cdb_valid[c] && (cdb_tag[c*TAGW +: TAGW] == tag)) begin
        r = {1'b1, cdb_val[c*XLEN +: XLEN]};
      end
    end
    return r;
  endfunction

  assign flush     = rst || jump_wrong_stall;
  assign ready_vec = busy & rdy1_q & rdy2_q;

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk   (clk),
    .clr   (flush),
    .alloc (alloc_oh),
    .free  (free_oh),
    .req   (ready_vec),
    .grant (sel_oh)
  );

  assign fire = rdy && (|ready_vec) && (!alu_valid || alu_ready);

  // Lowest free slot; when full, the slot leaving via dispatch is reused.
  always_comb begin
    ins_oh     = '0;
    slot_found = False;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!busy[i] && !slot_found) begin
        ins_oh[i]  = True;
        slot_found = True;
      end
    end
    if (!slot_found && fire) begin
      ins_oh = sel_oh;
    end
    insert   = rdy && issue_valid && (slot_found || fire);
    alloc_oh = insert ? ins_oh : '0;
    free_oh  = fire ? sel_oh : '0;
  end

  // Occupancy and next-cycle issue availability from registered busy state.
  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt = cnt + CW'(busy[i]);
    end
    free_cnt   = CW'(DEPTH) - cnt;
    rs_count   = cnt;
    rs_nex_ava = (free_cnt >= CW'(2)) || ((free_cnt == CW'(1)) && !issue_valid) || fire;
  end

  // CDB tag match for stored and incoming operands.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wk1[i] = cdb_lookup(vq1_q[i][TAGW-1:0]);
      wk2[i] = cdb_lookup(vq2_q[i][TAGW-1:0]);
    end
    in1 = cdb_lookup(issue_vq1[TAGW-1:0]);
    in2 = cdb_lookup(issue_vq2[TAGW-1:0]);
  end

  // Payload of the granted entry.
  always_comb begin
    sel_v1   = '0;
    sel_v2   = '0;
    sel_a    = '0;
    sel_pc   = '0;
    sel_code = '0;
    sel_rob  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) begin
        sel_v1   = vq1_q[i];
        sel_v2   = vq2_q[i];
        sel_a    = a_q[i];
        sel_pc   = pc_q[i];
        sel_code = code_q[i];
        sel_rob  = rob_q[i];
      end
    end
  end

  // Entry state: wakeup, free on dispatch, insert (insert wins on a reused slot).
  always_ff @(posedge clk) begin
    if (flush) begin
      busy <= '0;
    end else if (rdy) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (busy[i] && !rdy1_q[i] && wk1[i][XLEN]) begin
          rdy1_q[i] <= True;
          vq1_q[i]  <= wk1[i][XLEN-1:0];
        end
        if (busy[i] && !rdy2_q[i] && wk2[i][XLEN]) begin
          rdy2_q[i] <= True;
          vq2_q[i]  <= wk2[i][XLEN-1:0];
        end
        if (free_oh[i]) begin
          busy[i] <= False;
        end
        if (alloc_oh[i]) begin
          busy[i]   <= True;
          rdy1_q[i] <= issue_rdy1 || in1[XLEN];
          rdy2_q[i] <= issue_rdy2 || in2[XLEN];
          vq1_q[i]  <= (!issue_rdy1 && in1[XLEN]) ? in1[XLEN-1:0] : issue_vq1;
          vq2_q[i]  <= (!issue_rdy2 && in2[XLEN]) ? in2[XLEN-1:0] : issue_vq2;
          a_q[i]    <= issue_a;
          pc_q[i]   <= issue_pc;
          code_q[i] <= issue_code;
          rob_q[i]  <= issue_rob_id;
        end
      end
    end
  end

  // ALU output register: load on dispatch, drop valid once consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_valid  <= False;
      alu_v1     <= '0;
      alu_v2     <= '0;
      alu_a      <= '0;
      alu_pc     <= '0;
      alu_code   <= '0;
      alu_rob_id <= '0;
    end else if (jump_wrong_stall) begin
      alu_valid <= False;
    end else if (rdy) begin
      if (fire) begin
        alu_valid  <= True;
        alu_v1     <= sel_v1;
        alu_v2     <= sel_v2;
        alu_a      <= sel_a;
        alu_pc     <= sel_pc;
        alu_code   <= sel_code;
        alu_rob_id <= sel_rob;
      end else if (alu_ready) begin
        alu_valid <= False;
      end
    end
  end

  // Illegal usage: issue dropped while full, duplicate valid CDB tags.
  always_ff @(posedge clk) begin
    if (!flush && rdy) begin
      assert (!(issue_valid && !insert));
      for (int unsigned c1 = 0; c1 < NCDB; c1++) begin
        for (int unsigned c2 = c1 + 1; c2 < NCDB; c2++) begin
          assert (!(cdb_valid[c1] && cdb_valid[c2] &&
                    (cdb_tag[c1*TAGW +: TAGW] == cdb_tag[c2*TAGW +: TAGW])));
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_station_aged.sv
// Directed self-checking bench for rs_station_aged.
module tb_rs_station_aged;
  import rs_station_aged_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAGW  = 5;
  localparam int unsigned NCDB  = 2;
  localparam int unsigned CW    = 5;

  logic                 clk, rst, rdy, jump_wrong_stall;
  logic                 issue_valid, issue_rdy1, issue_rdy2;
  logic [XLEN-1:0]      issue_vq1, issue_vq2, issue_a, issue_pc;
  logic [5:0]           issue_code;
  logic [TAGW-1:0]      issue_rob_id;
  logic                 rs_nex_ava;
  logic [CW-1:0]        rs_count;
  logic                 alu_valid, alu_ready;
  logic [XLEN-1:0]      alu_v1, alu_v2, alu_a, alu_pc;
  logic [5:0]           alu_code;
  logic [TAGW-1:0]      alu_rob_id;
  logic [NCDB-1:0]      cdb_valid;
  logic [NCDB*TAGW-1:0] cdb_tag;
  logic [NCDB*XLEN-1:0] cdb_val;

  int n_cmp = 0;
  int n_err = 0;

  rs_station_aged #(.DEPTH(DEPTH), .XLEN(XLEN), .TAGW(TAGW), .NCDB(NCDB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong_stall(jump_wrong_stall),
    .issue_valid(issue_valid), .issue_vq1(issue_vq1), .issue_vq2(issue_vq2),
    .issue_rdy1(issue_rdy1), .issue_rdy2(issue_rdy2), .issue_a(issue_a),
    .issue_pc(issue_pc), .issue_code(issue_code), .issue_rob_id(issue_rob_id),
    .rs_nex_ava(rs_nex_ava), .rs_count(rs_count), .alu_valid(alu_valid),
    .alu_ready(alu_ready), .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_a(alu_a),
    .alu_pc(alu_pc), .alu_code(alu_code), .alu_rob_id(alu_rob_id),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    issue_rdy1   = 1'b1;
    issue_rdy2   = 1'b1;
    issue_vq1    = '0;
    issue_vq2    = '0;
    issue_a      = '0;
    issue_pc     = '0;
    issue_code   = '0;
    issue_rob_id = '0;
    cdb_valid    = '0;
    cdb_tag      = '0;
    cdb_val      = '0;
  endtask

  task automatic put(input logic [XLEN-1:0] v1, input logic r1,
                     input logic [XLEN-1:0] v2, input logic r2,
                     input logic [TAGW-1:0] rob, input logic [5:0] code);
    issue_valid  = 1'b1;
    issue_vq1    = v1;
    issue_rdy1   = r1;
    issue_vq2    = v2;
    issue_rdy2   = r2;
    issue_rob_id = rob;
    issue_code   = code;
    issue_a      = 32'h100 + 32'(rob);
    issue_pc     = 32'h1000 + (32'(rob) << 2);
  endtask

  task automatic do_reset();
    idle();
    rdy = 1'b1;
    jump_wrong_stall = 1'b0;
    alu_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0d exp 0", alu_valid); end
    n_cmp++; if ({alu_v1, alu_v2, alu_a, alu_pc, alu_code, alu_rob_id} !== '0) begin n_err++; $display("FAIL reset_data got v1=%0h v2=%0h a=%0h pc=%0h code=%0h rob=%0h exp all 0", alu_v1, alu_v2, alu_a, alu_pc, alu_code, alu_rob_id); end
    n_cmp++; if (rs_count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", rs_count); end
    n_cmp++; if (rs_nex_ava !== 1'b1) begin n_err++; $display("FAIL reset_ava got %0d exp 1", rs_nex_ava); end
  endtask

  task automatic test_basic();
    do_reset();
    put(32'd5, 1'b1, 32'd7, 1'b1, 5'd4, OP_ADD);
    tick();
    idle();
    n_cmp++; if (rs_count !== 5'd1) begin n_err++; $display("FAIL basic_count1 got %0d exp 1", rs_count); end
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got %0d exp 0", alu_valid); end
    tick();
    n_cmp++; if (alu_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %0d exp 1", alu_valid); end
    n_cmp++; if (alu_v1 !== 32'd5 || alu_v2 !== 32'd7) begin n_err++; $display("FAIL basic_ops got %0d,%0d exp 5,7", alu_v1, alu_v2); end
    n_cmp++; if (alu_a !== 32'h104 || alu_pc !== 32'h1010 || alu_code !== 6'd0 || alu_rob_id !== 5'd4) begin n_err++; $display("FAIL basic_fields got a=%0h pc=%0h code=%0d rob=%0d exp 104,1010,0,4", alu_a, alu_pc, alu_code, alu_rob_id); end
    n_cmp++; if (rs_count !== 5'd0) begin n_err++; $display("FAIL basic_count0 got %0d exp 0", rs_count); end
    tick();
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL basic_drop got %0d exp 0", alu_valid); end
  endtask

  task automatic test_wakeup();
    do_reset();
    put(32'd3, 1'b0, 32'd1, 1'b1, 5'd1, OP_SUB);
    tick();
    put(32'd2, 1'b1, 32'd2, 1'b1, 5'd2, OP_OR);
    tick();
    idle();
    n_cmp++; if (rs_count !== 5'd2) begin n_err++; $display("FAIL wake_count2 got %0d exp 2", rs_count); end
    tick();
    n_cmp++; if (alu_valid !== 1'b1 || alu_rob_id !== 5'd2) begin n_err++; $display("FAIL wake_first got v=%0d rob=%0d exp 1,2", alu_valid, alu_rob_id); end
    cdb_valid = 2'b10;
    cdb_tag   = {5'd3, 5'd0};
    cdb_val   = {32'h10, 32'h0};
    tick();
    idle();
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL wake_no_bypass got %0d exp 0", alu_valid); end
    tick();
    n_cmp++; if (alu_valid !== 1'b1 || alu_rob_id !== 5'd1) begin n_err++; $display("FAIL wake_second got v=%0d rob=%0d exp 1,1", alu_valid, alu_rob_id); end
    n_cmp++; if (alu_v1 !== 32'h10 || alu_v2 !== 32'd1 || alu_code !== 6'd1) begin n_err++; $display("FAIL wake_ops got v1=%0h v2=%0h code=%0d exp 10,1,1", alu_v1, alu_v2, alu_code); end
    n_cmp++; if (rs_count !== 5'd0) begin n_err++; $display("FAIL wake_count0 got %0d exp 0", rs_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    alu_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      put(32'(k), 1'b1, 32'(k + 1), 1'b1, 5'(k), OP_XOR);
      tick();
    end
    idle();
    n_cmp++; if (rs_count !== 5'd16) begin n_err++; $display("FAIL bp_full got %0d exp 16", rs_count); end
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (alu_valid !== 1'b1 || alu_rob_id !== 5'd0 || alu_v1 !== 32'd0 || alu_v2 !== 32'd1) begin n_err++; $display("FAIL bp_hold c=%0d got v=%0d rob=%0d v1=%0d v2=%0d exp 1,0,0,1", c, alu_valid, alu_rob_id, alu_v1, alu_v2); end
      n_cmp++; if (rs_nex_ava !== 1'b0) begin n_err++; $display("FAIL bp_ava c=%0d got %0d exp 0", c, rs_nex_ava); end
      tick();
    end
    alu_ready = 1'b1;
    #1;
    n_cmp++; if (rs_nex_ava !== 1'b1) begin n_err++; $display("FAIL bp_ava_release got %0d exp 1", rs_nex_ava); end
    for (int k = 1; k < 17; k++) begin
      tick();
      n_cmp++; if (alu_valid !== 1'b1 || alu_rob_id !== 5'(k) || alu_v1 !== 32'(k)) begin n_err++; $display("FAIL bp_order k=%0d got v=%0d rob=%0d v1=%0d", k, alu_valid, alu_rob_id, alu_v1); end
    end
    tick();
    n_cmp++; if (alu_valid !== 1'b0 || rs_count !== 5'd0) begin n_err++; $display("FAIL bp_drain got v=%0d cnt=%0d exp 0,0", alu_valid, rs_count); end
  endtask

  task automatic test_insert_capture();
    do_reset();
    put(32'h11, 1'b1, 32'd9, 1'b0, 5'd6, OP_AND);
    cdb_valid = 2'b01;
    cdb_tag   = {5'd0, 5'd9};
    cdb_val   = {32'h0, 32'hAB};
    tick();
    idle();
    n_cmp++; if (rs_count !== 5'd1 || alu_valid !== 1'b0) begin n_err++; $display("FAIL cap_stored got cnt=%0d v=%0d exp 1,0", rs_count, alu_valid); end
    tick();
    n_cmp++; if (alu_valid !== 1'b1 || alu_rob_id !== 5'd6) begin n_err++; $display("FAIL cap_dispatch got v=%0d rob=%0d exp 1,6", alu_valid, alu_rob_id); end
    n_cmp++; if (alu_v2 !== 32'hAB || alu_v1 !== 32'h11) begin n_err++; $display("FAIL cap_ops got v1=%0h v2=%0h exp 11,ab", alu_v1, alu_v2); end
  endtask

  task automatic test_flush();
    do_reset();
    alu_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      put(32'(k), 1'b1, 32'(k), 1'b1, 5'(k + 8), OP_SLL);
      tick();
    end
    idle();
    n_cmp++; if (rs_count !== 5'd3 || alu_valid !== 1'b1) begin n_err++; $display("FAIL flush_pre got cnt=%0d v=%0d exp 3,1", rs_count, alu_valid); end
    rdy = 1'b0;
    jump_wrong_stall = 1'b1;
    tick();
    jump_wrong_stall = 1'b0;
    rdy = 1'b1;
    #1;
    n_cmp++; if (rs_count !== 5'd0 || alu_valid !== 1'b0 || rs_nex_ava !== 1'b1) begin n_err++; $display("FAIL flush_post got cnt=%0d v=%0d ava=%0d exp 0,0,1", rs_count, alu_valid, rs_nex_ava); end
    alu_ready = 1'b1;
    tick();
    n_cmp++; if (alu_valid !== 1'b0) begin n_err++; $display("FAIL flush_ghost got %0d exp 0", alu_valid); end
  endtask

  task automatic test_rdy_hold();
    do_reset();
    alu_ready = 1'b0;
    put(32'd1, 1'b1, 32'd1, 1'b1, 5'd1, OP_SRL);
    tick();
    put(32'd2, 1'b1, 32'd2, 1'b1, 5'd2, OP_SRL);
    tick();
    rdy = 1'b0;
    alu_ready = 1'b1;
    put(32'd7, 1'b1, 32'd7, 1'b1, 5'd7, OP_SRL);
    tick();
    tick();
    idle();
    n_cmp++; if (rs_count !== 5'd1 || alu_valid !== 1'b1 || alu_rob_id !== 5'd1) begin n_err++; $display("FAIL hold_state got cnt=%0d v=%0d rob=%0d exp 1,1,1", rs_count, alu_valid, alu_rob_id); end
    rdy = 1'b1;
    tick();
    n_cmp++; if (alu_valid !== 1'b1 || alu_rob_id !== 5'd2 || rs_count !== 5'd0) begin n_err++; $display("FAIL hold_resume got v=%0d rob=%0d cnt=%0d exp 1,2,0", alu_valid, alu_rob_id, rs_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    alu_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      put(32'(k), 1'b1, 32'(k), 1'b1, 5'(k), OP_SLT);
      tick();
    end
    idle();
    n_cmp++; if (rs_count !== 5'd15) begin n_err++; $display("FAIL b2b_occ got %0d exp 15", rs_count); end
    alu_ready = 1'b1;
    put(32'd20, 1'b1, 32'd20, 1'b1, 5'd20, OP_SLT);
    #1;
    n_cmp++; if (rs_nex_ava !== 1'b1) begin n_err++; $display("FAIL b2b_ava got %0d exp 1", rs_nex_ava); end
    tick();
    idle();
    n_cmp++; if (rs_count !== 5'd15 || alu_rob_id !== 5'd1) begin n_err++; $display("FAIL b2b_same got cnt=%0d rob=%0d exp 15,1", rs_count, alu_rob_id); end
    for (int k = 2; k < 16; k++) begin
      tick();
      n_cmp++; if (alu_valid !== 1'b1 || alu_rob_id !== 5'(k)) begin n_err++; $display("FAIL b2b_order k=%0d got v=%0d rob=%0d", k, alu_valid, alu_rob_id); end
    end
    tick();
    n_cmp++; if (alu_valid !== 1'b1 || alu_rob_id !== 5'd20 || alu_v1 !== 32'd20) begin n_err++; $display("FAIL b2b_last got v=%0d rob=%0d v1=%0d exp 1,20,20", alu_valid, alu_rob_id, alu_v1); end
    tick();
    n_cmp++; if (alu_valid !== 1'b0 || rs_count !== 5'd0) begin n_err++; $display("FAIL b2b_empty got v=%0d cnt=%0d exp 0,0", alu_valid, rs_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_backpressure();
    test_insert_capture();
    test_flush();
    test_rdy_hold();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
